// File: rtl/fractal_sync_pkg.sv
// Shared parameters for the fractal synchronization tree.
package fractal_sync_pkg;

  localparam int unsigned SD_WIDTH = 8;

endpackage

// File: rtl/fractal_sync_mp_cnt_rf.sv
// Multi-port counting barrier register file: per-entry arrival counter with
// per-barrier target, registered per-port release pulses carrying the accumulated mask.
module fractal_sync_mp_cnt_rf #(
  parameter int unsigned N_REGS    = 4,
  parameter int unsigned IDX_WIDTH = 2,
  parameter int unsigned N_PORTS   = 4,
  parameter int unsigned CNT_WIDTH = 4,
  parameter int unsigned SD_WIDTH  = fractal_sync_pkg::SD_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic                 arrive_i     [N_PORTS],
  input  logic [CNT_WIDTH-1:0] target_i     [N_PORTS],
  input  logic [SD_WIDTH-1:0]  sd_i         [N_PORTS],
  input  logic [IDX_WIDTH-1:0] idx_i        [N_PORTS],
  input  logic                 idx_valid_i  [N_PORTS],
  output logic                 present_o    [N_PORTS],
  output logic [CNT_WIDTH-1:0] count_o      [N_PORTS],
  output logic                 release_o    [N_PORTS],
  output logic [SD_WIDTH-1:0]  release_sd_o [N_PORTS],
  output logic                 error_o
);

  localparam int unsigned IW  = (N_REGS > 1) ? $clog2(N_REGS) : 1;
  localparam int unsigned CW1 = CNT_WIDTH + 1;

  if (2**IDX_WIDTH < N_REGS) begin : g_idx_check
    $fatal(1, "IDX_WIDTH too small to address N_REGS entries");
  end

  typedef enum logic {
    IDLE     = 1'b0,
    COUNTING = 1'b1
  } entry_state_e;

  entry_state_e         state_q  [N_REGS];
  entry_state_e         state_d  [N_REGS];
  logic [CNT_WIDTH-1:0] count_q  [N_REGS];
  logic [CNT_WIDTH-1:0] count_d  [N_REGS];
  logic [CNT_WIDTH-1:0] target_q [N_REGS];
  logic [CNT_WIDTH-1:0] target_d [N_REGS];
  logic [SD_WIDTH-1:0]  sd_q     [N_REGS];
  logic [SD_WIDTH-1:0]  sd_d     [N_REGS];

  logic                 release_q    [N_PORTS];
  logic                 release_d    [N_PORTS];
  logic [SD_WIDTH-1:0]  release_sd_q [N_PORTS];
  logic [SD_WIDTH-1:0]  release_sd_d [N_PORTS];
  logic                 error_q;
  logic                 error_d;

  // Per-entry scratch for the update logic
  logic [N_PORTS-1:0]   hit_vec;
  logic [CW1-1:0]       hits;
  logic [CW1-1:0]       cnt_next;
  logic [SD_WIDTH-1:0]  sd_acc;
  logic [CNT_WIDTH-1:0] first_tgt;
  logic                 first_found;
  logic [CNT_WIDTH-1:0] tgt_eff;

  // A zero target still needs one participant to complete.
  function automatic logic [CNT_WIDTH-1:0] map_tgt(input logic [CNT_WIDTH-1:0] t);
    return (t == '0) ? CNT_WIDTH'(1) : t;
  endfunction

  function automatic logic port_sel(input logic [IDX_WIDTH-1:0] idx, input int e);
    return idx[IW-1:0] == IW'(e);
  endfunction

  always_comb begin
    for (int p = 0; p < N_PORTS; p++) begin
      present_o[p] = 1'b0;
      count_o[p]   = '0;
      if (idx_valid_i[p]) begin
        for (int e = 0; e < N_REGS; e++) begin
          if (port_sel(idx_i[p], e) && state_q[e] == COUNTING) begin
            present_o[p] = 1'b1;
            count_o[p]   = count_q[e];
          end
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    target_d    = target_q;
    sd_d        = sd_q;
    error_d     = 1'b0;
    hit_vec     = '0;
    hits        = '0;
    cnt_next    = '0;
    sd_acc      = '0;
    first_tgt   = '0;
    first_found = 1'b0;
    tgt_eff     = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      release_d[p]    = 1'b0;
      release_sd_d[p] = '0;
    end

    for (int e = 0; e < N_REGS; e++) begin
      hit_vec     = '0;
      hits        = '0;
      sd_acc      = sd_q[e];
      first_tgt   = '0;
      first_found = 1'b0;
      for (int p = 0; p < N_PORTS; p++) begin
        if (idx_valid_i[p] && arrive_i[p] && port_sel(idx_i[p], e)) begin
          hit_vec[p] = 1'b1;
          hits       = hits + CW1'(1);
          sd_acc     = sd_acc | sd_i[p];
          if (!first_found) begin
            first_tgt   = target_i[p];
            first_found = 1'b1;
          end
        end
      end

      tgt_eff  = (state_q[e] == COUNTING) ? target_q[e] : map_tgt(first_tgt);
      cnt_next = {1'b0, count_q[e]} + hits;

      if (hits != '0) begin
        for (int p = 0; p < N_PORTS; p++) begin
          if (hit_vec[p] && map_tgt(target_i[p]) != tgt_eff) error_d = 1'b1;
        end
        if (cnt_next >= {1'b0, tgt_eff}) begin
          state_d[e]  = IDLE;
          count_d[e]  = '0;
          target_d[e] = '0;
          sd_d[e]     = '0;
          if (cnt_next > {1'b0, tgt_eff}) error_d = 1'b1;
          for (int p = 0; p < N_PORTS; p++) begin
            if (hit_vec[p]) begin
              release_d[p]    = 1'b1;
              release_sd_d[p] = sd_acc;
            end
          end
        end else begin
          state_d[e]  = COUNTING;
          count_d[e]  = cnt_next[CNT_WIDTH-1:0];
          target_d[e] = tgt_eff;
          sd_d[e]     = sd_acc;
        end
      end
    end

    // Flush overrides every update computed above, including releases.
    if (flush_i) begin
      error_d = 1'b0;
      for (int e = 0; e < N_REGS; e++) begin
        state_d[e]  = IDLE;
        count_d[e]  = '0;
        target_d[e] = '0;
        sd_d[e]     = '0;
      end
      for (int p = 0; p < N_PORTS; p++) begin
        release_d[p]    = 1'b0;
        release_sd_d[p] = '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int e = 0; e < N_REGS; e++) begin
        state_q[e]  <= IDLE;
        count_q[e]  <= '0;
        target_q[e] <= '0;
        sd_q[e]     <= '0;
      end
      for (int p = 0; p < N_PORTS; p++) begin
        release_q[p]    <= 1'b0;
        release_sd_q[p] <= '0;
      end
      error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      target_q     <= target_d;
      sd_q         <= sd_d;
      release_q    <= release_d;
      release_sd_q <= release_sd_d;
      error_q      <= error_d;
    end
  end

  assign release_o    = release_q;
  assign release_sd_o = release_sd_q;
  assign error_o      = error_q;

endmodule

// File: tb/tb_fractal_sync_mp_cnt_rf.sv
// Self-checking bench: directed barrier scenarios plus random traffic against a rule-level model.
module tb_fractal_sync_mp_cnt_rf;

  localparam int NR = 4;
  localparam int NP = 4;
  localparam int CW = 4;
  localparam int SW = fractal_sync_pkg::SD_WIDTH;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          arrive    [NP];
  logic [CW-1:0] target    [NP];
  logic [SW-1:0] sd        [NP];
  logic [1:0]    idx       [NP];
  logic          idx_valid [NP];
  logic          present   [NP];
  logic [CW-1:0] count     [NP];
  logic          rel       [NP];
  logic [SW-1:0] rel_sd    [NP];
  logic          error;

  fractal_sync_mp_cnt_rf #(
    .N_REGS(NR), .IDX_WIDTH(2), .N_PORTS(NP), .CNT_WIDTH(CW), .SD_WIDTH(SW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .arrive_i(arrive), .target_i(target), .sd_i(sd), .idx_i(idx), .idx_valid_i(idx_valid),
    .present_o(present), .count_o(count), .release_o(rel), .release_sd_o(rel_sd),
    .error_o(error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: one open barrier per entry, tracked as plain integers.
  int m_open [NR];
  int m_cnt  [NR];
  int m_tgt  [NR];
  int m_sd   [NR];
  int exp_rel [NP];
  int exp_rsd [NP];
  int exp_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
  endtask

  function automatic int eff_tgt(input int t);
    return (t == 0) ? 1 : t;
  endfunction

  task automatic model_reset();
    for (int e = 0; e < NR; e++) begin
      m_open[e] = 0; m_cnt[e] = 0; m_tgt[e] = 0; m_sd[e] = 0;
    end
    for (int p = 0; p < NP; p++) begin
      exp_rel[p] = 0; exp_rsd[p] = 0;
    end
    exp_err = 0;
  endtask

  task automatic model_step();
    for (int p = 0; p < NP; p++) begin
      exp_rel[p] = 0; exp_rsd[p] = 0;
    end
    exp_err = 0;
    if (flush) begin
      model_reset();
      return;
    end
    for (int e = 0; e < NR; e++) begin
      int hitters[$];
      int acc;
      int tgt;
      acc = m_sd[e];
      for (int p = 0; p < NP; p++)
        if (idx_valid[p] && arrive[p] && int'(idx[p]) == e) hitters.push_back(p);
      if (hitters.size() == 0) continue;
      tgt = m_open[e] ? m_tgt[e] : eff_tgt(int'(target[hitters[0]]));
      foreach (hitters[i]) begin
        acc = acc | int'(sd[hitters[i]]);
        if (eff_tgt(int'(target[hitters[i]])) != tgt) exp_err = 1;
      end
      if (m_cnt[e] + hitters.size() >= tgt) begin
        if (m_cnt[e] + hitters.size() > tgt) exp_err = 1;
        foreach (hitters[i]) begin
          exp_rel[hitters[i]] = 1;
          exp_rsd[hitters[i]] = acc;
        end
        m_open[e] = 0; m_cnt[e] = 0; m_tgt[e] = 0; m_sd[e] = 0;
      end else begin
        m_open[e] = 1;
        m_cnt[e]  = m_cnt[e] + hitters.size();
        m_tgt[e]  = tgt;
        m_sd[e]   = acc;
      end
    end
  endtask

  task automatic check_regs();
    for (int p = 0; p < NP; p++) begin
      check($sformatf("release[%0d]", p), 32'(rel[p]), 32'(exp_rel[p]));
      check($sformatf("release_sd[%0d]", p), 32'(rel_sd[p]), 32'(exp_rsd[p]));
    end
    check("error", 32'(error), 32'(exp_err));
  endtask

  // Inputs are already applied just after a falling edge.
  task automatic do_cycle();
    #1;
    for (int p = 0; p < NP; p++) begin
      int ep;
      ep = idx_valid[p] ? m_open[idx[p]] : 0;
      check($sformatf("present[%0d]", p), 32'(present[p]), 32'(ep));
      check($sformatf("count[%0d]", p), 32'(count[p]), ep ? 32'(m_cnt[idx[p]]) : 32'd0);
    end
    model_step();
    @(negedge clk);
    check_regs();
  endtask

  task automatic clear_inputs();
    flush = 1'b0;
    for (int p = 0; p < NP; p++) begin
      arrive[p] = 1'b0; target[p] = '0; sd[p] = '0; idx[p] = '0; idx_valid[p] = 1'b0;
    end
  endtask

  task automatic arr(input int p, input int e, input int t, input int s);
    arrive[p] = 1'b1; idx_valid[p] = 1'b1; idx[p] = 2'(e); target[p] = CW'(t); sd[p] = SW'(s);
  endtask

  task automatic observe(input int p, input int e);
    arrive[p] = 1'b0; idx_valid[p] = 1'b1; idx[p] = 2'(e);
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    model_reset();
    #2;
    check_regs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Three-way barrier on entry 1, port 3 watching.
    clear_inputs(); arr(0, 1, 3, 1); observe(3, 1); do_cycle();
    clear_inputs(); arr(1, 1, 3, 2); observe(3, 1); do_cycle();
    clear_inputs(); arr(2, 1, 3, 4); observe(3, 1); do_cycle();
    check("t1_release_sd2", 32'(rel_sd[2]), 32'h7);
    clear_inputs(); observe(3, 1); do_cycle();

    // All four ports complete entry 0 together.
    clear_inputs();
    for (int p = 0; p < NP; p++) arr(p, 0, 4, 1 << p);
    do_cycle();
    check("t2_release_sd0", 32'(rel_sd[0]), 32'hf);
    check("t2_error", 32'(error), 32'h0);

    // Overshoot on entry 2.
    clear_inputs(); arr(0, 2, 2, 1); do_cycle();
    clear_inputs(); arr(1, 2, 2, 2); arr(3, 2, 2, 8); observe(0, 2); do_cycle();
    check("t3_error", 32'(error), 32'h1);

    // Zero target completes on first arrival; then a target mismatch.
    clear_inputs(); arr(0, 2, 0, 3); do_cycle();
    check("t4_zero_release", 32'(rel[0]), 32'h1);
    clear_inputs(); arr(0, 1, 3, 1); do_cycle();
    clear_inputs(); arr(1, 1, 5, 2); do_cycle();
    check("t4_mismatch_err", 32'(error), 32'h1);
    clear_inputs(); observe(2, 1); do_cycle();
    clear_inputs(); arr(2, 1, 3, 4); do_cycle();

    // Back-to-back barriers on entry 3.
    clear_inputs(); arr(0, 3, 2, 8'h10); do_cycle();
    clear_inputs(); arr(1, 3, 2, 8'h20); do_cycle();
    clear_inputs(); arr(2, 3, 2, 8'h01); do_cycle();
    clear_inputs(); observe(3, 3); do_cycle();
    clear_inputs(); arr(0, 3, 2, 8'h02); do_cycle();
    check("t5_fresh_sd", 32'(rel_sd[0]), 32'h03);

    // Flush while counting at 2.
    clear_inputs(); arr(0, 1, 4, 1); arr(1, 1, 4, 2); do_cycle();
    clear_inputs(); arr(2, 1, 4, 4); arr(3, 1, 4, 8); flush = 1'b1; do_cycle();
    clear_inputs(); observe(0, 1); do_cycle();
    check("t6_flush_present", 32'(present[0]), 32'h0);
    clear_inputs(); arr(0, 1, 1, 5); do_cycle();

    // Asynchronous reset while counting at 2.
    clear_inputs(); arr(0, 0, 4, 1); arr(1, 0, 4, 2); do_cycle();
    clear_inputs(); observe(2, 0); #1;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("t7_rst_present", 32'(present[2]), 32'h0);
    check_regs();
    @(negedge clk);
    rst_n = 1'b1;
    clear_inputs(); arr(1, 0, 2, 1); do_cycle();
    clear_inputs(); arr(2, 0, 2, 2); do_cycle();

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      clear_inputs();
      flush = ($urandom_range(0, 99) == 0);
      for (int p = 0; p < NP; p++) begin
        idx_valid[p] = ($urandom_range(0, 3) != 0);
        arrive[p]    = ($urandom_range(0, 2) != 0);
        idx[p]       = 2'($urandom_range(0, NR - 1));
        target[p]    = ($urandom_range(0, 9) == 0) ? CW'($urandom_range(0, 6)) : CW'(idx[p] + 1);
        sd[p]        = SW'($urandom);
      end
      do_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fractal_sync_mp_cnt_rf.md
# fractal_sync_mp_cnt_rf

Multi-port counting barrier register file for the fractal synchronization tree. Each entry tracks an N-way barrier instead of a 1-bit toggle: arrivals from any port accumulate into a per-entry counter until a per-barrier target is reached. Completing ports then receive a registered release pulse together with the back-routing source/destination mask accumulated over the whole barrier. The block sits in a tree node in place of the toggle-style RF when a node must synchronise more than two participants.

## Interface
- N_REGS, 4, number of barrier entries
- IDX_WIDTH, 2, entry index width; fatal elaboration check 2**IDX_WIDTH >= N_REGS
- N_PORTS, 4, number of arrival ports
- CNT_WIDTH, 4, width of counter and target
- SD_WIDTH, fractal_sync_pkg::SD_WIDTH, back-routing mask width
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  synchronous clear of all entries; highest priority
- arrive_i[N_PORTS]  in  1  arrival on selected entry (qualified by idx_valid_i)
- target_i[N_PORTS]  in  CNT_WIDTH  participants expected; sampled only when opening a barrier
- sd_i[N_PORTS]  in  SD_WIDTH  source/destination mask ORed into the entry
- idx_i[N_PORTS]  in  IDX_WIDTH  entry index; low $clog2(N_REGS) bits used (1 bit if N_REGS=1)
- idx_valid_i[N_PORTS]  in  1  index valid
- present_o[N_PORTS]  out  1  selected entry is COUNTING (combinational)
- count_o[N_PORTS]  out  CNT_WIDTH  current count of selected entry, 0 if not present
- release_o[N_PORTS]  out  1  registered: this port's arrival completed a barrier last cycle
- release_sd_o[N_PORTS]  out  SD_WIDTH  registered final mask of that barrier; 0 when release_o=0
- error_o  out  1  registered pulse: overshoot or target mismatch last cycle

## Operation
- Per-entry state: IDLE/COUNTING, count_q, target_q, sd_q. Reset: all IDLE, all fields 0; all registered outputs 0.
- Per cycle, per entry e: hits = number of ports with idx_valid && arrive && idx==e (width $clog2(N_PORTS+1), zero-extended to CNT_WIDTH+1); sd_acc = sd_q | OR of sd_i of hitting ports.
- Target select: IDLE entry with hits>0 latches target_i of the lowest-numbered hitting port; target 0 treated as 1. COUNTING entry keeps target_q.
- Mismatch: a hitting port with target_i != effective target (after 0->1 mapping) sets error; arrival still counted.
- cnt_next = count_q + hits computed at CNT_WIDTH+1 bits. If cnt_next >= target: complete -> entry to IDLE, count/sd/target cleared; every hitting port p of that cycle gets release_q[p]<=1, release_sd_q[p]<=sd_acc. If cnt_next > target: error also set.
- Else if hits>0: COUNTING, count_q<=cnt_next, sd_q<=sd_acc.
- An entry completing in cycle t accepts a new barrier in cycle t+1; no release-hold state.
- flush_i: all entries IDLE, fields 0, arrivals that cycle discarded, release_q and error_q forced 0 next cycle.
- Ports with idx_valid_i=0 have no effect; present_o=0, count_o=0.

## Timing
- present_o/count_o: combinational from state registers, reflect pre-update state (the arrival itself is not visible until next cycle).
- Arrival -> count update: 1 cycle. Completing arrival at edge t -> release_o high for exactly cycle t+1 (single-cycle pulse unless re-completed).
- Multiple ports completing the same entry in the same cycle all release; different entries completing simultaneously release independently.
- error_o: 1-cycle pulse following the offending cycle.
- Reset mid-barrier: all state lost, outputs 0 asynchronously; no release is ever issued for aborted barriers.

## Test plan
- N_PORTS=4, target 3 on entry 1: ports 0,1,2 arrive on cycles 0,1,2 (sd 0x1,0x2,0x4) -> present_o high cycles 1-2, count_o 1 then 2; release_o[2]=1 cycle 3 with release_sd_o=0x7, others 0; entry IDLE cycle 3.
- Simultaneous: ports 0-3 arrive on entry 0 same cycle, target 4 -> all four release_o=1 next cycle, release_sd_o=OR of masks, error_o=0.
- Overshoot: target 2, count 1, ports 1 and 3 arrive together -> both release, error_o pulses, entry IDLE.
- Mismatch/zero target: port 0 opens entry 2 with target 0 -> immediate release next cycle; port 1 arrives with target 5 on an entry opened with 3 -> error_o pulse, count increments.
- Back-to-back: barrier on entry 3 completes cycle t, new arrival cycle t+1 -> opens fresh barrier, count_o=1 cycle t+2, sd not carrying old bits.
- flush_i and async reset during COUNTING with count 2 -> present_o=0 after, no release_o, error_o 0; subsequent barrier behaves as from reset.
